// File: rtl/mem_pkg.sv
// Shared types and constants for the RAM access sequencer (mem_ctrl).
// Optional build macro used by the sequencer: MEMCTRL_PERF_EN.
package mem_pkg;

  // One RAM access in flight: request accepted in IDLE, RAM touched in
  // ACCESS, result held in RESP until the CPU takes it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mc_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } mc_port_t;

  // CPU byte address -> RAM word address shift.
  localparam int WORD_OFS = 2;

  // Grant choice for the current IDLE cycle. Data wins a tie unless it
  // also won the previous grant, so a busy data port cannot starve fetch.
  // With no valid the result is irrelevant; PORT_I is returned.
  function automatic mc_port_t pick_port(input logic     i_valid,
                                         input logic     d_valid,
                                         input mc_port_t last);
    mc_port_t sel;
    sel = PORT_I;
    if (d_valid && !i_valid) begin
      sel = PORT_D;
    end else if (i_valid && !d_valid) begin
      sel = PORT_I;
    end else if (i_valid && d_valid) begin
      sel = (last == PORT_D) ? PORT_I : PORT_D;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_perf_cnt.sv
// Access and stall event counters for mem_ctrl. Only instantiated when
// MEMCTRL_PERF_EN is defined. Counters wrap at 2^32 and clear on reset.
module mem_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_fetch,
  input  logic        inc_load,
  input  logic        inc_store,
  input  logic        inc_stall,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_load,
  output logic [31:0] perf_store,
  output logic [31:0] perf_stall
);

  // One free-running counter per event class; wrap is natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch <= '0;
      perf_load  <= '0;
      perf_store <= '0;
      perf_stall <= '0;
    end else begin
      if (inc_fetch) perf_fetch <= perf_fetch + 32'd1;
      if (inc_load)  perf_load  <= perf_load  + 32'd1;
      if (inc_store) perf_store <= perf_store + 32'd1;
      if (inc_stall) perf_stall <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port RAM sequencer: arbitrates the instruction-fetch port and the
// load/store port onto one RAM access at a time and returns results on
// valid/ready response channels.
// Optional build macro: MEMCTRL_PERF_EN adds perf_fetch/load/store/stall.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting; combinational grant drives the winning req_ready
// ACCESS | one cycle on the RAM: read enable or write enable + bus drive
// RESP   | response valid held stable until the granted port takes it
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [AWIDTH-1:0] i_req_addr,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DWIDTH-1:0] i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [AWIDTH-1:0] d_req_addr,
  input  logic [DWIDTH-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DWIDTH-1:0] d_rsp_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic              mem_rd_en,
  output logic              mem_wr_en
`ifdef MEMCTRL_PERF_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_load,
  output logic [31:0]       perf_store,
  output logic [31:0]       perf_stall
`endif
);

  mc_state_t         state;
  mc_port_t          last_grant;
  mc_port_t          cur_port;
  mc_port_t          grant;
  logic              cur_we;
  logic [DWIDTH-1:0] wdata_q;
  logic [AWIDTH-1:0] addr_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic              accept_i;
  logic              accept_d;
  logic              drive_bus;
  logic [AWIDTH-1:0] i_word;
  logic [AWIDTH-1:0] d_word;
  logic              unused_byte_ofs;

  // Byte offsets within a word carry no meaning for a word-wide RAM.
  assign unused_byte_ofs = ^{i_req_addr[WORD_OFS-1:0], d_req_addr[WORD_OFS-1:0]};

  assign i_word = {{WORD_OFS{1'b0}}, i_req_addr[AWIDTH-1:WORD_OFS]};
  assign d_word = {{WORD_OFS{1'b0}}, d_req_addr[AWIDTH-1:WORD_OFS]};

  // Grant and ready are combinational on the valids, only in IDLE and
  // never while reset is asserted.
  always_comb begin
    grant       = pick_port(i_req_valid, d_req_valid, last_grant);
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    if (!reset && state == IDLE) begin
      i_req_ready = i_req_valid && (grant == PORT_I);
      d_req_ready = d_req_valid && (grant == PORT_D);
    end
  end

  assign accept_i = i_req_valid && i_req_ready;
  assign accept_d = d_req_valid && d_req_ready;

  // The write strobe and bus driver are gated by reset so that a reset
  // landing in a store ACCESS cannot complete the write.
  assign drive_bus = wr_en_q && !reset;
  assign mem_wr_en = drive_bus;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign mem_data  = drive_bus ? wdata_q : {DWIDTH{1'bz}};

  // Sequencer: latch the accepted request, run one RAM cycle, hold result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= PORT_I;
      cur_port    <= PORT_I;
      cur_we      <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_d) begin
            cur_port   <= PORT_D;
            last_grant <= PORT_D;
            cur_we     <= d_req_we;
            wdata_q    <= d_req_wdata;
            addr_q     <= d_word;
            rd_en_q    <= !d_req_we;
            wr_en_q    <= d_req_we;
            state      <= ACCESS;
          end else if (accept_i) begin
            cur_port   <= PORT_I;
            last_grant <= PORT_I;
            cur_we     <= 1'b0;
            addr_q     <= i_word;
            rd_en_q    <= 1'b1;
            wr_en_q    <= 1'b0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          addr_q  <= '0;
          if (cur_port == PORT_I) begin
            i_rsp_valid <= 1'b1;
            i_rsp_data  <= mem_data;
          end else begin
            d_rsp_valid <= 1'b1;
            d_rsp_rdata <= cur_we ? '0 : mem_data;
          end
          state <= RESP;
        end
        RESP: begin
          if (cur_port == PORT_I) begin
            if (i_rsp_ready) begin
              i_rsp_valid <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            if (d_rsp_ready) begin
              d_rsp_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          addr_q  <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef MEMCTRL_PERF_EN
  logic stall;

  // A stall is any cycle where a requester is waiting on its ready.
  assign stall = (i_req_valid && !i_req_ready) || (d_req_valid && !d_req_ready);

  mem_perf_cnt u_perf (
    .clk        (clk),
    .reset      (reset),
    .inc_fetch  (accept_i),
    .inc_load   (accept_d && !d_req_we),
    .inc_store  (accept_d && d_req_we),
    .inc_stall  (stall),
    .perf_fetch (perf_fetch),
    .perf_load  (perf_load),
    .perf_store (perf_store),
    .perf_stall (perf_stall)
  );
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl with a small behavioural RAM (word k preloaded with
// 0xC0DE0000 + k). Optional section under MEMCTRL_PERF_EN.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] i_rsp_data;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_req_we = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic [31:0] d_req_wdata = '0;
  logic        d_rsp_valid;
  logic        d_rsp_ready = 1'b1;
  logic [31:0] d_rsp_rdata;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic        tb_drv_en = 1'b0;
  logic [31:0] tb_drv_val = '0;
`ifdef MEMCTRL_PERF_EN
  logic [31:0] perf_fetch, perf_load, perf_store, perf_stall;
`endif

  logic [31:0] ram [0:63];
  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic        exp_g_q[$];

  mem_ctrl #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .i_rsp_data  (i_rsp_data),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_ready (d_rsp_ready),
    .d_rsp_rdata (d_rsp_rdata),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en)
`ifdef MEMCTRL_PERF_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_load   (perf_load),
    .perf_store  (perf_store),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // RAM: combinational read onto the bus, write at the clock edge.
  // The bench can also drive the bus to prove the controller has released it.
  assign mem_data = mem_rd_en ? ram[mem_addr[5:0]] : (tb_drv_en ? tb_drv_val : 32'hzzzz_zzzz);

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 64; k++) ram[k] <= 32'hC0DE_0000 + k;
    end else if (mem_wr_en) begin
      ram[mem_addr[5:0]] <= mem_data;
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) wr_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none queued", nm);
  endtask

  // Scoreboard monitor: grant order on every accept, data on every response.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_req_valid && i_req_ready) begin
        if (exp_g_q.size() == 0) unexpected("grant_i");
        else check("grant_order", 32'd0, {31'd0, exp_g_q.pop_front()});
      end
      if (d_req_valid && d_req_ready) begin
        if (exp_g_q.size() == 0) unexpected("grant_d");
        else check("grant_order", 32'd1, {31'd0, exp_g_q.pop_front()});
      end
      if (i_rsp_valid && i_rsp_ready) begin
        if (exp_i_q.size() == 0) unexpected("i_rsp");
        else check("i_rsp_data", i_rsp_data, exp_i_q.pop_front());
      end
      if (d_rsp_valid && d_rsp_ready) begin
        if (exp_d_q.size() == 0) unexpected("d_rsp");
        else check("d_rsp_rdata", d_rsp_rdata, exp_d_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch, return 1 time unit after the accepting edge.
  task automatic issue_i(input logic [31:0] a);
    int n;
    n = 0;
    i_req_addr  = a;
    i_req_valid = 1'b1;
    #1;
    while (!i_req_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) unexpected("i_accept_timeout");
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    d_req_we    = we;
    d_req_addr  = a;
    d_req_wdata = wd;
    d_req_valid = 1'b1;
    #1;
    while (!d_req_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) unexpected("d_accept_timeout");
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0;
    repeat (2) step();
    preload = 1'b0;
    check("rst_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
    check("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_i_rsp_data", i_rsp_data, 32'd0);
    check("rst_d_rsp_rdata", d_rsp_rdata, 32'd0);
    reset = 1'b0;
    step();

    // 1: lone fetch of byte 0x10 -> word 4
    exp_g_q.push_back(1'b0);
    exp_i_q.push_back(32'hC0DE_0004);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    issue_i(32'h10);
    check("t1_access_rd_en", {31'd0, mem_rd_en}, 32'd1);
    check("t1_access_addr", mem_addr, 32'd4);
    check("t1_no_early_valid", {31'd0, i_rsp_valid}, 32'd0);
    step();
    check("t1_rsp_valid", {31'd0, i_rsp_valid}, 32'd1);
    check("t1_addr_idle", mem_addr, 32'd0);
    step();
    check("t1_rd_cycles", rd_cnt - rd0, 32'd1);
    check("t1_wr_cycles", wr_cnt - wr0, 32'd0);

    // 2: store then load at byte 0x20 -> word 8
    exp_g_q.push_back(1'b1);
    exp_d_q.push_back(32'h0);
    issue_d(1'b1, 32'h20, 32'hDEAD_BEEF);
    check("t2_wr_en", {31'd0, mem_wr_en}, 32'd1);
    check("t2_rd_en_off", {31'd0, mem_rd_en}, 32'd0);
    check("t2_bus_wdata", mem_data, 32'hDEAD_BEEF);
    check("t2_addr", mem_addr, 32'd8);
    step();
    check("t2_ack_valid", {31'd0, d_rsp_valid}, 32'd1);
    check("t2_wr_en_off", {31'd0, mem_wr_en}, 32'd0);
    check("t2_ram_written", ram[8], 32'hDEAD_BEEF);
    tb_drv_en  = 1'b1;
    tb_drv_val = 32'h5A5A_5A5A;
    #1;
    check("t2_bus_released", mem_data, 32'h5A5A_5A5A);
    tb_drv_en = 1'b0;
    step();
    exp_g_q.push_back(1'b1);
    exp_d_q.push_back(32'hDEAD_BEEF);
    issue_d(1'b0, 32'h20, 32'h0);
    check("t2_load_rd_en", {31'd0, mem_rd_en}, 32'd1);
    repeat (2) step();

    // 3: contested requests alternate d,i,d,i from a fresh last-grant
    pulse_reset();
    exp_g_q.push_back(1'b1);
    exp_g_q.push_back(1'b0);
    exp_g_q.push_back(1'b1);
    exp_g_q.push_back(1'b0);
    exp_d_q.push_back(32'hC0DE_0001);
    exp_d_q.push_back(32'hC0DE_0002);
    exp_i_q.push_back(32'hC0DE_0003);
    exp_i_q.push_back(32'hC0DE_0005);
    fork
      begin
        issue_d(1'b0, 32'h04, 32'h0);
        issue_d(1'b0, 32'h08, 32'h0);
      end
      begin
        issue_i(32'h0C);
        issue_i(32'h14);
      end
    join
    repeat (4) step();

    // 4: data response back-pressured for 5 cycles with a fetch waiting
    exp_g_q.push_back(1'b1);
    exp_d_q.push_back(32'hC0DE_0002);
    exp_g_q.push_back(1'b0);
    exp_i_q.push_back(32'hC0DE_0000);
    d_rsp_ready = 1'b0;
    issue_d(1'b0, 32'h08, 32'h0);
    step();
    i_req_addr  = 32'h0;
    i_req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t4_hold_valid", {31'd0, d_rsp_valid}, 32'd1);
      check("t4_hold_rdata", d_rsp_rdata, 32'hC0DE_0002);
      check("t4_i_ready_low", {31'd0, i_req_ready}, 32'd0);
      check("t4_d_ready_low", {31'd0, d_req_ready}, 32'd0);
      step();
    end
    d_rsp_ready = 1'b1;
    issue_i(32'h0);
    repeat (3) step();

    // 5: reset during a store ACCESS must not write
    exp_g_q.push_back(1'b1);
    issue_d(1'b1, 32'h30, 32'h1234_5678);
    reset      = 1'b1;
    tb_drv_en  = 1'b1;
    tb_drv_val = 32'h0F0F_0F0F;
    #1;
    check("t5_wr_gated", {31'd0, mem_wr_en}, 32'd0);
    check("t5_bus_gated", mem_data, 32'h0F0F_0F0F);
    step();
    tb_drv_en = 1'b0;
    check("t5_ram_kept", ram[12], 32'hC0DE_000C);
    check("t5_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
    check("t5_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
    check("t5_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("t5_addr", mem_addr, 32'd0);
    check("t5_d_rdata", d_rsp_rdata, 32'd0);
    check("t5_ready", {30'd0, i_req_ready, d_req_ready}, 32'd0);
    reset = 1'b0;
    step();
    exp_g_q.push_back(1'b1);
    exp_d_q.push_back(32'hC0DE_000C);
    issue_d(1'b0, 32'h30, 32'h0);
    repeat (2) step();

`ifdef MEMCTRL_PERF_EN
    // 6: 3 fetch, 2 load, 1 store; the final contested pair gives 3 stall
    // cycles (accept of i, its ACCESS, its RESP) before d is taken.
    pulse_reset();
    exp_g_q.push_back(1'b0); exp_i_q.push_back(32'hC0DE_0000);
    exp_g_q.push_back(1'b0); exp_i_q.push_back(32'hC0DE_0001);
    exp_g_q.push_back(1'b1); exp_d_q.push_back(32'hC0DE_0001);
    exp_g_q.push_back(1'b1); exp_d_q.push_back(32'h0);
    exp_g_q.push_back(1'b0); exp_i_q.push_back(32'hC0DE_0002);
    exp_g_q.push_back(1'b1); exp_d_q.push_back(32'hC0DE_0003);
    issue_i(32'h00);                  repeat (2) step();
    issue_i(32'h04);                  repeat (2) step();
    issue_d(1'b0, 32'h04, 32'h0);     repeat (2) step();
    issue_d(1'b1, 32'h3C, 32'h1);     repeat (2) step();
    fork
      issue_i(32'h08);
      issue_d(1'b0, 32'h0C, 32'h0);
    join
    repeat (3) step();
    check("t6_perf_fetch", perf_fetch, 32'd3);
    check("t6_perf_load", perf_load, 32'd2);
    check("t6_perf_store", perf_store, 32'd1);
    check("t6_perf_stall", perf_stall, 32'd3);
`endif

    check("left_grant", exp_g_q.size(), 32'd0);
    check("left_i_rsp", exp_i_q.size(), 32'd0);
    check("left_d_rsp", exp_d_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
